// File: rtl/avalon_st_if.sv
// Avalon-ST message stream bundle: payload and framing flow master -> slave,
// ready flows back.
interface avalon_st_if #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);
    logic               valid;
    logic               ready;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;

    modport master (output valid, sop, eop, empty, data, input ready);
    modport slave  (input valid, sop, eop, empty, data, output ready);
endinterface

// File: rtl/avalon_msg_limiter.sv
// Forwards Avalon-ST messages through a one-deep output register, cutting any
// message longer than MAX_WORDS and discarding its tail; reports each length.
module avalon_msg_limiter #(
    parameter int MAX_WORDS = 16,
    parameter int CNT_WIDTH = $clog2(MAX_WORDS + 1),
    parameter int DATA_W    = 32,
    parameter int EMPTY_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           in_msg,
    avalon_st_if.master          out_msg,
    output logic                 truncated_error,
    output logic                 last_msg_valid,
    output logic [CNT_WIDTH-1:0] last_msg_words
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_MSG = 2'd1,
        DROP   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_WORDS);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic [EMPTY_W-1:0]   out_empty_q, out_empty_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 trunc_q, trunc_d;
    logic                 lmv_q, lmv_d;
    logic [CNT_WIDTH-1:0] lmw_q, lmw_d;

    logic                 in_ready;
    logic                 accept;
    logic                 fwd;
    logic                 force_eop;
    logic                 report;
    logic [CNT_WIDTH-1:0] rep_len;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // DROP never stalls upstream: the discarded tail does not touch the output register.
    assign in_ready = (state_q == DROP) ? 1'b1 : (~out_valid_q | out_msg.ready);
    assign accept   = in_msg.valid & in_ready;
    assign cnt_inc  = cnt_q + ONE_C;

    assign in_msg.ready    = in_ready;
    assign out_msg.valid   = out_valid_q;
    assign out_msg.sop     = out_sop_q;
    assign out_msg.eop     = out_eop_q;
    assign out_msg.empty   = out_empty_q;
    assign out_msg.data    = out_data_q;
    assign truncated_error = trunc_q;
    assign last_msg_valid  = lmv_q;
    assign last_msg_words  = lmw_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        out_data_d  = out_data_q;
        fwd         = 1'b0;
        force_eop   = 1'b0;
        report      = 1'b0;
        trunc_d     = 1'b0;
        rep_len     = lmw_q;

        if (out_valid_q && out_msg.ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Words without sop here are stray tails and are silently dropped.
                if (accept && in_msg.sop) begin
                    fwd   = 1'b1;
                    cnt_d = ONE_C;
                    if (in_msg.eop) begin
                        report  = 1'b1;
                        rep_len = ONE_C;
                    end else if (MAX_WORDS == 1) begin
                        force_eop = 1'b1;
                        trunc_d   = 1'b1;
                        report    = 1'b1;
                        rep_len   = ONE_C;
                        state_d   = DROP;
                    end else begin
                        state_d = IN_MSG;
                    end
                end
            end
            IN_MSG: begin
                if (accept) begin
                    fwd   = 1'b1;
                    cnt_d = cnt_inc;
                    if (in_msg.eop) begin
                        report  = 1'b1;
                        rep_len = cnt_inc;
                        state_d = IDLE;
                    end else if (cnt_inc == MAX_C) begin
                        force_eop = 1'b1;
                        trunc_d   = 1'b1;
                        report    = 1'b1;
                        rep_len   = MAX_C;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && in_msg.eop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fwd) begin
            out_valid_d = 1'b1;
            out_sop_d   = in_msg.sop;
            out_eop_d   = force_eop ? 1'b1 : in_msg.eop;
            out_empty_d = force_eop ? '0 : in_msg.empty;
            out_data_d  = in_msg.data;
        end

        lmv_d = report;
        lmw_d = rep_len;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_data_q  <= '0;
            trunc_q     <= 1'b0;
            lmv_q       <= 1'b0;
            lmw_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_data_q  <= out_data_d;
            trunc_q     <= trunc_d;
            lmv_q       <= lmv_d;
            lmw_q       <= lmw_d;
        end
    end

endmodule

// File: doc/avalon_msg_limiter.md
Name: avalon_msg_limiter

Overview:
Sits directly downstream of the Avalon-ST protocol enforcer and consumes its protocol-clean message stream. It forwards messages through a one-deep registered output stage with full valid/ready backpressure. It counts words per message and truncates any message longer than MAX_WORDS by forcing eop on word MAX_WORDS, then discards the remainder up to the original eop. It reports truncation and the length of every completed message.

Parameters:
MAX_WORDS, 16, maximum words per forwarded message; legal range >= 1.
CNT_WIDTH, $clog2(MAX_WORDS+1), width of the word counter and of the length report.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
in_msg  avalon_st_if.slave  interface-defined  input stream (valid, sop, eop, empty, data in; ready out).
out_msg  avalon_st_if.master  interface-defined  output stream (valid, sop, eop, empty, data out; ready in).
truncated_error  output  1  one-cycle pulse: the current message was cut at MAX_WORDS.
last_msg_valid  output  1  one-cycle pulse: last_msg_words updated.
last_msg_words  output  CNT_WIDTH  word count of the last forwarded message, after truncation.

Behaviour:
- Reset (rst low, async): state IDLE, word counter 0. out_msg.valid/sop/eop/empty/data all 0. truncated_error 0, last_msg_valid 0, last_msg_words 0. Takes effect immediately, including mid-message. After release, the next accepted word must carry sop.
- Handshake: accept = in_msg.valid & in_msg.ready.
  - In DROP: in_msg.ready = 1.
  - Otherwise: in_msg.ready = ~out_msg.valid | out_msg.ready (combinational).
- Output register: loaded on every accept that is forwarded; latency is 1 cycle. While out_msg.valid & ~out_msg.ready, all out_msg fields hold stable. out_msg.valid clears when the word is taken and no new word loads that cycle.
- Forwarded fields: data, sop and empty are copied from the input. eop is copied, or forced as below. When eop is forced, empty is forced to 0.
- States:
  - IDLE:
    - Accept with sop: forward the word, count = 1.
    - If eop is also set: stay in IDLE and report length 1.
    - Else if MAX_WORDS == 1: force eop, truncate, go to DROP.
    - Else: go to IN_MSG.
    - Accept without sop (protocol violation upstream): word discarded, no state change.
  - IN_MSG:
    - Each accept forwards the word and increments count.
    - Input eop: go to IDLE, report count+1.
    - Else if count+1 == MAX_WORDS: force eop, truncate, report MAX_WORDS, go to DROP.
    - An sop inside IN_MSG is forwarded as-is; upstream guarantees it does not occur.
  - DROP:
    - Every accepted word is discarded; the output register is untouched and keeps draining independently.
    - Accept with eop: go to IDLE.
- Reporting:
  - last_msg_words is registered on the accept that ends the forwarded message.
  - last_msg_valid pulses high one cycle, in the cycle that word first appears on out_msg.
  - truncated_error pulses in the same cycle, only for a forced eop.
  - Reports hold until the next update; they are never cleared except by reset.
- Boundary conditions:
  - Message of exactly MAX_WORDS words ending in eop: normal end. No truncation, no DROP.
  - A word with sop & eop in DROP ends DROP (treated as the remainder's end).
  - Backpressure in the cycle a truncation is decided: the forced-eop word still loads only on accept. Truncation is decided on that same accept, never speculatively.
  - Counter never exceeds MAX_WORDS, so there is no wrap.

Test Plan:
- Reset and idle: hold rst low 3 cycles with in_msg.valid=1. Required: all outputs 0, no word appears. Then release rst and send a 1-word sop+eop, data=0xA5. Required: out_msg shows sop=1, eop=1, data=0xA5 one cycle after accept; last_msg_words=1; last_msg_valid pulses once.
- Normal message: MAX_WORDS=16, 5-word message, out_msg.ready=1. Required: 5 words out with 1-cycle latency; sop on word 1 and eop on word 5 unchanged; last_msg_words=5; truncated_error stays 0.
- Exact limit: 16-word message with eop on word 16. Required: passed unchanged, last_msg_words=16, no truncated_error, state returns to IDLE.
- Truncation: 20-word message, empty=2 on word 20. Required:
  - Word 16 is output with eop=1 and empty=0.
  - truncated_error and last_msg_valid pulse together, last_msg_words=16.
  - Words 17-20 are accepted with ready=1 and never appear on out_msg.
  - A following 3-word message is forwarded normally.
- Backpressure: 4-word message, out_msg.ready toggled 1,0,0,1,... Required: in_msg.ready low whenever the output register is full and out_msg.ready is 0; out_msg fields stable while stalled; all 4 words delivered in order with no loss or duplication.
- Reset mid-message: assert rst after word 3 of a 10-word message. Required: outputs 0 immediately. After release, the 7 remaining non-sop words are discarded in IDLE, and the next sop message is forwarded normally.
